// File: rtl/stack_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stack_seq_ctrl                                               |
// | Description : Expands PUSH/POP/CALL/RET/INT/RTI into 16-bit stack beats,   |
// |               owns the stack pointer and stalls the front end until done.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stack_seq_ctrl #(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   input  logic [2:0]        op_code,
   input  logic [31:0]       pc_in,
   input  logic [3:0]        flags_in,
   input  logic [15:0]       push_data,
   input  logic              mem_gnt,
   input  logic [15:0]       mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              stall,
   output logic              done,
   output logic              pc_load,
   output logic [31:0]       pc_out,
   output logic              flags_load,
   output logic [3:0]        flags_out,
   output logic              pop_valid,
   output logic [15:0]       pop_data,
   output logic [ADDR_W-1:0] sp_out
);

   localparam logic [2:0] c_OP_PUSH = 3'd0;
   localparam logic [2:0] c_OP_POP  = 3'd1;
   localparam logic [2:0] c_OP_CALL = 3'd2;
   localparam logic [2:0] c_OP_RET  = 3'd3;
   localparam logic [2:0] c_OP_INT  = 3'd4;
   localparam logic [2:0] c_OP_RTI  = 3'd5;
   localparam logic [ADDR_W-1:0] c_SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BEAT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_beat;
   logic [2:0]        r_op;
   logic [31:0]       r_pc;
   logic [3:0]        r_flags;
   logic [15:0]       r_pdata;
   logic [15:0]       r_rd_lo;
   logic [3:0]        r_rd_flags;
   logic [ADDR_W-1:0] r_sp;
   logic [31:0]       r_pc_out;
   logic [3:0]        r_flags_out;
   logic [15:0]       r_pop_data;

   logic              w_accept;
   logic              w_fire;
   logic              w_is_push;
   logic              w_last;
   logic [1:0]        w_n_beats;
   logic [15:0]       w_push_word;

   assign w_accept  = op_valid && (op_code <= c_OP_RTI) && (r_state != S_BEAT);
   assign w_fire    = (r_state == S_BEAT) && mem_gnt;
   assign w_is_push = (r_op == c_OP_PUSH) || (r_op == c_OP_CALL) || (r_op == c_OP_INT);
   assign w_last    = (r_beat == (w_n_beats - 2'd1));

   always_comb begin
      w_n_beats = 2'd1;
      case (r_op)
         c_OP_CALL, c_OP_RET: w_n_beats = 2'd2;
         c_OP_INT,  c_OP_RTI: w_n_beats = 2'd3;
         default:             w_n_beats = 2'd1;
      endcase
   end

   // Saved PC goes high half first so the return path pops low half first.
   always_comb begin
      w_push_word = 16'h0000;
      case (r_op)
         c_OP_PUSH: w_push_word = r_pdata;
         c_OP_CALL: w_push_word = (r_beat == 2'd0) ? r_pc[31:16] : r_pc[15:0];
         c_OP_INT: begin
            case (r_beat)
               2'd0:    w_push_word = r_pc[31:16];
               2'd1:    w_push_word = r_pc[15:0];
               default: w_push_word = {12'h000, r_flags};
            endcase
         end
         default:   w_push_word = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = 16'h0000;
      done        = 1'b0;
      pc_load     = 1'b0;
      flags_load  = 1'b0;
      pop_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_BEAT;
         end
         S_BEAT: begin
            mem_req   = 1'b1;
            mem_we    = w_is_push;
            mem_addr  = w_is_push ? r_sp : (r_sp + c_SP_ONE);
            mem_wdata = w_is_push ? w_push_word : 16'h0000;
            if (mem_gnt && w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            pc_load     = (r_op == c_OP_RET) || (r_op == c_OP_RTI);
            flags_load  = (r_op == c_OP_RTI);
            pop_valid   = (r_op == c_OP_POP);
            w_state_nxt = w_accept ? S_BEAT : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Restored values are committed only on the final beat so they stay
   // stable from one DONE to the next.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sp        <= SP_RESET;
         r_beat      <= 2'd0;
         r_op        <= 3'd0;
         r_pc        <= 32'h0;
         r_flags     <= 4'h0;
         r_pdata     <= 16'h0;
         r_rd_lo     <= 16'h0;
         r_rd_flags  <= 4'h0;
         r_pc_out    <= 32'h0;
         r_flags_out <= 4'h0;
         r_pop_data  <= 16'h0;
      end else if (w_accept) begin
         r_op    <= op_code;
         r_pc    <= pc_in;
         r_flags <= flags_in;
         r_pdata <= push_data;
         r_beat  <= 2'd0;
      end else if (w_fire) begin
         r_sp   <= w_is_push ? (r_sp - c_SP_ONE) : (r_sp + c_SP_ONE);
         r_beat <= w_last ? 2'd0 : (r_beat + 2'd1);
         case (r_op)
            c_OP_POP: r_pop_data <= mem_rdata;
            c_OP_RET: begin
               if (r_beat == 2'd0) r_rd_lo  <= mem_rdata;
               else                r_pc_out <= {mem_rdata, r_rd_lo};
            end
            c_OP_RTI: begin
               case (r_beat)
                  2'd0: r_rd_flags <= mem_rdata[3:0];
                  2'd1: r_rd_lo    <= mem_rdata;
                  default: begin
                     r_pc_out    <= {mem_rdata, r_rd_lo};
                     r_flags_out <= r_rd_flags;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   assign stall     = (r_state == S_BEAT) || w_accept;
   assign pc_out    = r_pc_out;
   assign flags_out = r_flags_out;
   assign pop_data  = r_pop_data;
   assign sp_out    = r_sp;

endmodule
`default_nettype wire

// File: tb/tb_stack_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stack_seq_ctrl                                            |
// | Description : Directed self-checking bench for stack_seq_ctrl.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stack_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] pc_in;
   logic [3:0]  flags_in;
   logic [15:0] push_data;
   logic        mem_gnt;
   logic [15:0] mem_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        stall;
   logic        done;
   logic        pc_load;
   logic [31:0] pc_out;
   logic        flags_load;
   logic [3:0]  flags_out;
   logic        pop_valid;
   logic [15:0] pop_data;
   logic [11:0] sp_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] mem [0:4095];

   always #5 clk = ~clk;

   stack_seq_ctrl #(.ADDR_W(12), .SP_RESET(12'hFFF)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .pc_in(pc_in), .flags_in(flags_in), .push_data(push_data),
      .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .stall(stall), .done(done), .pc_load(pc_load), .pc_out(pc_out),
      .flags_load(flags_load), .flags_out(flags_out), .pop_valid(pop_valid),
      .pop_data(pop_data), .sp_out(sp_out)
   );

   // Simple data memory: combinational read, write on a granted push beat.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_req && mem_gnt && mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", mem_req); end
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", stall); end
      n_tests++; if (sp_out !== 12'hFFF) begin n_fail++; $display("FAIL rst_sp: got %h exp fff", sp_out); end
      n_tests++; if ({done, pc_load, flags_load, pop_valid, pc_out, flags_out, pop_data} !== 56'h0) begin
         n_fail++; $display("FAIL rst_outs: got %h exp 0", {done, pc_load, flags_load, pop_valid, pc_out, flags_out, pop_data}); end
   endtask

   task automatic test_call();
      op_valid = 1'b1; op_code = 3'd2; pc_in = 32'h0001_2345; mem_gnt = 1'b1;
      #1;
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL call_c0_stall: got %b exp 1", stall); end
      cyc(); op_valid = 1'b0; #1;
      n_tests++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'hFFF, 16'h0001}) begin
         n_fail++; $display("FAIL call_b0: got req/we/addr/data %b%b %h %h exp 11 fff 0001", mem_req, mem_we, mem_addr, mem_wdata); end
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL call_c1_stall: got %b exp 1", stall); end
      cyc(); #1;
      n_tests++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'hFFE, 16'h2345}) begin
         n_fail++; $display("FAIL call_b1: got req/we/addr/data %b%b %h %h exp 11 ffe 2345", mem_req, mem_we, mem_addr, mem_wdata); end
      cyc(); #1;
      n_tests++; if ({done, stall, mem_req} !== 3'b100) begin n_fail++; $display("FAIL call_done: got done/stall/req %b exp 100", {done, stall, mem_req}); end
      n_tests++; if (sp_out !== 12'hFFD) begin n_fail++; $display("FAIL call_sp: got %h exp ffd", sp_out); end
      n_tests++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL call_pcload: got %b exp 0", pc_load); end
   endtask

   task automatic test_ret();
      cyc();
      op_valid = 1'b1; op_code = 3'd3;
      cyc(); op_valid = 1'b0; #1;
      n_tests++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 12'hFFE}) begin
         n_fail++; $display("FAIL ret_b0: got req/we/addr %b%b %h exp 10 ffe", mem_req, mem_we, mem_addr); end
      cyc(); #1;
      n_tests++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 12'hFFF}) begin
         n_fail++; $display("FAIL ret_b1: got req/we/addr %b%b %h exp 10 fff", mem_req, mem_we, mem_addr); end
      cyc(); #1;
      n_tests++; if ({done, pc_load, flags_load} !== 3'b110) begin n_fail++; $display("FAIL ret_done: got done/pcl/fl %b exp 110", {done, pc_load, flags_load}); end
      n_tests++; if (pc_out !== 32'h0001_2345) begin n_fail++; $display("FAIL ret_pc: got %h exp 00012345", pc_out); end
      n_tests++; if (sp_out !== 12'hFFF) begin n_fail++; $display("FAIL ret_sp: got %h exp fff", sp_out); end
   endtask

   task automatic test_int_wait();
      cyc();
      op_valid = 1'b1; op_code = 3'd4; pc_in = 32'hABCD_0010; flags_in = 4'b1010;
      cyc(); op_valid = 1'b0; mem_gnt = 1'b0; #1;
      for (int k = 0; k < 2; k++) begin
         n_tests++; if ({mem_req, mem_we, mem_addr, mem_wdata, sp_out} !== {2'b11, 12'hFFF, 16'hABCD, 12'hFFF}) begin
            n_fail++; $display("FAIL int_wait%0d: got req/we/addr/data/sp %b%b %h %h %h exp 11 fff abcd fff", k, mem_req, mem_we, mem_addr, mem_wdata, sp_out); end
         cyc(); #1;
      end
      mem_gnt = 1'b1; #1;
      n_tests++; if ({mem_addr, mem_wdata} !== {12'hFFF, 16'hABCD}) begin
         n_fail++; $display("FAIL int_b0: got addr/data %h %h exp fff abcd", mem_addr, mem_wdata); end
      cyc(); #1;
      n_tests++; if ({mem_addr, mem_wdata} !== {12'hFFE, 16'h0010}) begin
         n_fail++; $display("FAIL int_b1: got addr/data %h %h exp ffe 0010", mem_addr, mem_wdata); end
      cyc(); #1;
      n_tests++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFD, 16'h000A}) begin
         n_fail++; $display("FAIL int_b2: got we/addr/data %b %h %h exp 1 ffd 000a", mem_we, mem_addr, mem_wdata); end
      cyc(); #1;
      n_tests++; if ({done, sp_out} !== {1'b1, 12'hFFC}) begin n_fail++; $display("FAIL int_done: got done/sp %b %h exp 1 ffc", done, sp_out); end
   endtask

   task automatic test_back_to_back();
      op_valid = 1'b1; op_code = 3'd5;
      #1;
      n_tests++; if ({done, stall} !== 2'b11) begin n_fail++; $display("FAIL b2b_accept: got done/stall %b exp 11", {done, stall}); end
      cyc(); op_valid = 1'b0; #1;
      n_tests++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 12'hFFD}) begin
         n_fail++; $display("FAIL rti_b0: got req/we/addr %b%b %h exp 10 ffd", mem_req, mem_we, mem_addr); end
      cyc(); #1;
      n_tests++; if (mem_addr !== 12'hFFE) begin n_fail++; $display("FAIL rti_b1: got %h exp ffe", mem_addr); end
      cyc(); #1;
      n_tests++; if (mem_addr !== 12'hFFF) begin n_fail++; $display("FAIL rti_b2: got %h exp fff", mem_addr); end
      cyc(); #1;
      n_tests++; if ({done, pc_load, flags_load, pop_valid} !== 4'b1110) begin
         n_fail++; $display("FAIL rti_done: got done/pcl/fl/pv %b exp 1110", {done, pc_load, flags_load, pop_valid}); end
      n_tests++; if ({pc_out, flags_out} !== {32'hABCD_0010, 4'b1010}) begin
         n_fail++; $display("FAIL rti_data: got pc/flags %h %b exp abcd0010 1010", pc_out, flags_out); end
      n_tests++; if (sp_out !== 12'hFFF) begin n_fail++; $display("FAIL rti_sp: got %h exp fff", sp_out); end
      cyc(); #1;
      n_tests++; if ({done, pc_load, pc_out, flags_out} !== {2'b00, 32'hABCD_0010, 4'b1010}) begin
         n_fail++; $display("FAIL rti_hold: got done/pcl/pc/flags %b%b %h %b exp 00 abcd0010 1010", done, pc_load, pc_out, flags_out); end
   endtask

   task automatic test_reserved();
      op_valid = 1'b1; op_code = 3'd6;
      #1;
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rsv_stall: got %b exp 0", stall); end
      cyc(); #1;
      n_tests++; if ({mem_req, stall, done} !== 3'b000) begin n_fail++; $display("FAIL rsv_idle: got req/stall/done %b exp 000", {mem_req, stall, done}); end
      op_valid = 1'b0;
   endtask

   task automatic test_pop_wrap();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      op_valid = 1'b1; op_code = 3'd1;
      cyc(); op_valid = 1'b0; #1;
      n_tests++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 12'h000}) begin
         n_fail++; $display("FAIL pop_addr: got req/we/addr %b%b %h exp 10 000", mem_req, mem_we, mem_addr); end
      cyc(); #1;
      n_tests++; if ({done, pop_valid, pop_data, sp_out} !== {2'b11, 16'hBEEF, 12'h000}) begin
         n_fail++; $display("FAIL pop_done: got done/pv/data/sp %b%b %h %h exp 11 beef 000", done, pop_valid, pop_data, sp_out); end
      cyc();
      op_valid = 1'b1; op_code = 3'd0; push_data = 16'h1234;
      cyc(); op_valid = 1'b0; #1;
      n_tests++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h000, 16'h1234}) begin
         n_fail++; $display("FAIL push_beat: got we/addr/data %b %h %h exp 1 000 1234", mem_we, mem_addr, mem_wdata); end
      cyc(); #1;
      n_tests++; if ({done, pop_valid, sp_out, mem[0]} !== {2'b10, 12'hFFF, 16'h1234}) begin
         n_fail++; $display("FAIL push_done: got done/pv/sp/mem0 %b%b %h %h exp 10 fff 1234", done, pop_valid, sp_out, mem[0]); end
   endtask

   task automatic test_reset_mid();
      cyc();
      op_valid = 1'b1; op_code = 3'd2; pc_in = 32'h5555_AAAA;
      cyc(); op_valid = 1'b0;
      cyc(); reset = 1'b1;
      cyc(); reset = 1'b0; #1;
      n_tests++; if ({mem_req, stall, done, sp_out} !== {3'b000, 12'hFFF}) begin
         n_fail++; $display("FAIL rstmid: got req/stall/done/sp %b %h exp 000 fff", {mem_req, stall, done}, sp_out); end
      for (int k = 0; k < 3; k++) begin
         cyc(); #1;
         n_tests++; if ({done, mem_req} !== 2'b00) begin n_fail++; $display("FAIL rstmid_quiet%0d: got done/req %b exp 00", k, {done, mem_req}); end
      end
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
      mem[0] = 16'hBEEF;
      reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; pc_in = 32'h0;
      flags_in = 4'h0; push_data = 16'h0; mem_gnt = 1'b1;
      test_reset();
      test_call();
      test_ret();
      test_int_wait();
      test_back_to_back();
      test_reserved();
      test_pop_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
